pad_shift_reader: RTL and testbench

PAD_SHIFT_READER -- requirements
Module: pad_shift_reader

---
 rtl/pad_shift_reader_pkg.sv | 38 +++
 rtl/pad_shift_reader_if.sv | 14 +
 rtl/pad_sync.sv | 23 ++
 rtl/pad_shift_reader.sv | 116 +++++++++++
 tb/tb_pad_shift_reader.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/pad_shift_reader_pkg.sv
// Shared game-pad controller definitions: FSM states, button bit positions
// and the raw-frame to button-vector mapping.
package pad_shift_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETTLE,
    S_PULSE_HI,
    S_PULSE_LO,
    S_DONE
  } state_t;

  localparam int unsigned BTN_START  = 7;
  localparam int unsigned BTN_SELECT = 6;
  localparam int unsigned BTN_B      = 5;
  localparam int unsigned BTN_A      = 4;
  localparam int unsigned BTN_DOWN   = 3;
  localparam int unsigned BTN_UP     = 2;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 0;

  // Raw frame arrives A,B,SELECT,START,UP,DOWN,LEFT,RIGHT and is active-low.
  function automatic logic [7:0] frame_to_buttons(input logic [7:0] frame);
    logic [7:0] b;
    b            = '0;
    b[BTN_A]      = ~frame[0];
    b[BTN_B]      = ~frame[1];
    b[BTN_SELECT] = ~frame[2];
    b[BTN_START]  = ~frame[3];
    b[BTN_UP]     = ~frame[4];
    b[BTN_DOWN]   = ~frame[5];
    b[BTN_LEFT]   = ~frame[6];
    b[BTN_RIGHT]  = ~frame[7];
    return b;
  endfunction

endpackage

// File: rtl/pad_shift_reader_if.sv
// Pad-side and host-side signals of the pad shift reader.
interface pad_shift_reader_if;
  logic       I_DATA;
  logic       O_LATCH;
  logic       O_PULSE;
  logic [7:0] O_BUTTONS;
  logic       O_VALID;
  logic       O_BUSY;

  modport slave  (input  I_DATA,
                  output O_LATCH, O_PULSE, O_BUTTONS, O_VALID, O_BUSY);
  modport master (output I_DATA,
                  input  O_LATCH, O_PULSE, O_BUTTONS, O_VALID, O_BUSY);
endinterface

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the asynchronous pad data line; resets to the
// idle (released) level.
module pad_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/pad_shift_reader.sv
// Polls a serial game pad: latch, shift out 8 bits, publish active-high buttons.
// Optional PAD_DEBOUNCE_EN: publish only when two consecutive frames agree.
module pad_shift_reader
  import pad_shift_reader_pkg::*;
#(
  parameter int unsigned HALF_PERIOD   = 200,
  parameter int unsigned POLL_INTERVAL = 550000
) (
  input  logic                I_CLK,
  input  logic                I_RESET,
  pad_shift_reader_if.slave   bus
);
  localparam int unsigned PHASE_W = (HALF_PERIOD   > 1) ? $clog2(HALF_PERIOD)   : 1;
  localparam int unsigned POLL_W  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(HALF_PERIOD - 1);
  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_INTERVAL - 1);

  state_t               r_state, w_next;
  logic [PHASE_W-1:0]   r_phase, w_phase_nxt;
  logic [POLL_W-1:0]    r_poll, w_poll_nxt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_frame;
  logic                 r_latch, r_pulse, r_busy, r_valid;
  logic [7:0]           r_buttons;
  logic                 w_capture;
  logic                 w_sync;
`ifdef PAD_DEBOUNCE_EN
  logic [7:0]           r_prev_frame;
`endif

  pad_sync u_sync (
    .i_clk (I_CLK),
    .i_rst (I_RESET),
    .i_d   (bus.I_DATA),
    .o_q   (w_sync)
  );

  always_comb begin
    w_next      = r_state;
    w_phase_nxt = '0;
    w_poll_nxt  = '0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE:
        if (r_poll == POLL_LAST) w_next = S_LATCH;
        else                     w_poll_nxt = r_poll + POLL_W'(1);
      S_LATCH:
        if (r_phase == PHASE_LAST) w_next = S_SETTLE;
        else                       w_phase_nxt = r_phase + PHASE_W'(1);
      S_SETTLE:
        if (r_phase == PHASE_LAST) begin
          w_capture = 1'b1;
          w_next    = S_PULSE_HI;
        end else w_phase_nxt = r_phase + PHASE_W'(1);
      S_PULSE_HI:
        if (r_phase == PHASE_LAST) w_next = S_PULSE_LO;
        else                       w_phase_nxt = r_phase + PHASE_W'(1);
      S_PULSE_LO:
        if (r_phase == PHASE_LAST) begin
          w_capture = 1'b1;
          w_next    = (r_bit_idx == 3'd7) ? S_DONE : S_PULSE_HI;
        end else w_phase_nxt = r_phase + PHASE_W'(1);
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_poll    <= '0;
      r_bit_idx <= '0;
      r_frame   <= '0;
      r_latch   <= 1'b0;
      r_pulse   <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_buttons <= '0;
`ifdef PAD_DEBOUNCE_EN
      r_prev_frame <= '1;
`endif
    end else begin
      r_state <= w_next;
      r_phase <= w_phase_nxt;
      r_poll  <= w_poll_nxt;
      r_latch <= (w_next == S_LATCH);
      r_pulse <= (w_next == S_PULSE_HI);
      r_busy  <= (w_next != S_IDLE);
      r_valid <= 1'b0;
      if (w_capture) begin
        r_frame[r_bit_idx] <= w_sync;
        r_bit_idx          <= r_bit_idx + 3'd1;
      end
      if (r_state == S_DONE) begin
`ifdef PAD_DEBOUNCE_EN
        r_prev_frame <= r_frame;
        if (r_frame == r_prev_frame) begin
          r_buttons <= frame_to_buttons(r_frame);
          r_valid   <= 1'b1;
        end
`else
        r_buttons <= frame_to_buttons(r_frame);
        r_valid   <= 1'b1;
`endif
      end
    end
  end

  assign bus.O_LATCH   = r_latch;
  assign bus.O_PULSE   = r_pulse;
  assign bus.O_BUSY    = r_busy;
  assign bus.O_VALID   = r_valid;
  assign bus.O_BUTTONS = r_buttons;
endmodule

// File: tb/tb_pad_shift_reader.sv
// Bench for pad_shift_reader: pad shift-register model, frame-timing model
// and directed button patterns with literal expectations.
module tb_pad_shift_reader;
  localparam int HP = 4;
  localparam int PI = 100;
  localparam int FP = PI + 2*HP + 7*2*HP + 1;

  logic clk = 1'b0;
  logic rst;
  pad_shift_reader_if bus ();

  pad_shift_reader #(.HALF_PERIOD(HP), .POLL_INTERVAL(PI)) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic [7:0] pressed  = 8'h00;
  logic [7:0] image    = 8'h00;
  logic [7:0] exp_btn  = 8'h00;
  logic [7:0] prev_img = 8'h00;
  int order [8] = '{4, 5, 6, 7, 2, 3, 1, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycles since the last reset edge; a frame is FP cycles starting in IDLE.
  initial forever @(posedge clk) begin
    if (rst) begin
      t        = 0;
      exp_btn  = 8'h00;
      prev_img = 8'h00;
    end else t = t + 1;
  end

  // Pad model plus per-cycle comparison against the frame-timing model.
  initial begin
    int p, q, pad_idx;
    logic e_latch, e_pulse, e_busy, e_valid, pulse_prev, valid_prev;
    pad_idx = 8; pulse_prev = 1'b0; valid_prev = 1'b0;
    bus.I_DATA = 1'b1;
    forever begin
      @(negedge clk);
      p = t % FP;
      q = p - (PI + 2*HP);
      e_latch = (p >= PI) && (p < PI + HP);
      e_pulse = (p >= PI + 2*HP) && (p < FP - 1) && ((q % (2*HP)) < HP);
      e_busy  = (p >= PI);
      e_valid = 1'b0;
      if (p == 0 && t > 0) begin
`ifdef PAD_DEBOUNCE_EN
        e_valid  = (image == prev_img);
        prev_img = image;
`else
        e_valid = 1'b1;
`endif
        if (e_valid) exp_btn = image;
      end
      chk("latch", bus.O_LATCH, e_latch);
      chk("pulse", bus.O_PULSE, e_pulse);
      chk("busy", bus.O_BUSY, e_busy);
      chk("valid", bus.O_VALID, e_valid);
      chk("buttons", bus.O_BUTTONS, exp_btn);
      chk("latch_and_pulse", bus.O_LATCH & bus.O_PULSE, 0);
      chk("valid_twice", bus.O_VALID & valid_prev, 0);
      valid_prev = bus.O_VALID;
      if (bus.O_LATCH) begin
        image   = pressed;
        pad_idx = 0;
      end else if (bus.O_PULSE && !pulse_prev) pad_idx++;
      pulse_prev = bus.O_PULSE;
      bus.I_DATA = (pad_idx < 8) ? ~image[order[pad_idx]] : 1'b1;
    end
  end

  task automatic wait_valid(input int budget, output int cyc, output int np);
    logic pp;
    cyc = 0; np = 0; pp = bus.O_PULSE;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.O_PULSE && !pp) np++;
      pp = bus.O_PULSE;
    end while (!bus.O_VALID && cyc < budget);
    if (!bus.O_VALID) chk("valid_timeout", bus.O_VALID, 1);
  endtask

  initial begin
    int n, np, nv;
    logic pp;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_buttons", bus.O_BUTTONS, 8'h00);
    chk("rst_busy", bus.O_BUSY, 0);
    chk("rst_latch", bus.O_LATCH, 0);
    rst = 1'b0;

    n = 0;
    do begin @(negedge clk); n++; end while (!bus.O_LATCH && n < 300);
    chk("first_latch_delay", n, PI);
    n = 0;
    while (bus.O_LATCH && n < 50) begin @(negedge clk); n++; end
    chk("latch_width", n, HP);
    wait_valid(300, n, np);
    chk("pulse_count", np, 7);
    chk("idle_frame_buttons", bus.O_BUTTONS, 8'h00);

    pressed = 8'h10; wait_valid(400, n, np);
    chk("btn_A", bus.O_BUTTONS, 8'h10);
    pressed = 8'h80; wait_valid(400, n, np);
    chk("btn_START", bus.O_BUTTONS, 8'h80);
    pressed = 8'h01; wait_valid(400, n, np);
    chk("btn_RIGHT", bus.O_BUTTONS, 8'h01);
    pressed = 8'hFF; wait_valid(400, n, np);
    chk("btn_all", bus.O_BUTTONS, 8'hFF);
    wait_valid(400, n, np);
    chk("frame_period", n, FP);

    np = 0; n = 0; pp = bus.O_PULSE;
    while (np < 3 && n < 300) begin
      @(negedge clk); n++;
      if (bus.O_PULSE && !pp) np++;
      pp = bus.O_PULSE;
    end
    chk("third_pulse_seen", np, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pulse", bus.O_PULSE, 0);
    chk("midrst_busy", bus.O_BUSY, 0);
    chk("midrst_buttons", bus.O_BUTTONS, 8'h00);
    chk("midrst_valid", bus.O_VALID, 0);
    pressed = 8'h00;
    rst = 1'b0;
    wait_valid(400, n, np);
    chk("post_rst_valid_delay", n, FP);

`ifdef PAD_DEBOUNCE_EN
    pressed = 8'h04; wait_valid(500, n, np);
    chk("db_up_up_delay", n, 2*FP);
    chk("db_up_buttons", bus.O_BUTTONS, 8'h04);
    pressed = 8'h08; nv = 0;
    repeat (FP + 20) begin @(negedge clk); if (bus.O_VALID) nv++; end
    chk("db_down_no_valid", nv, 0);
    chk("db_down_buttons", bus.O_BUTTONS, 8'h04);
`else
    pressed = 8'h04; wait_valid(400, n, np);
    chk("up_delay", n, FP);
    chk("up_buttons", bus.O_BUTTONS, 8'h04);
    nv = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
